// File: rtl/multi_trigger.sv
// Multi-channel debounced edge trigger; optional event counter under `MULTI_TRIGGER_CNT_EN.
// Latency: an input change sampled at edge k, held stable, shows on the outputs at edge k+Deb_Len+2.
// Backpressure: none; events are produced every cycle they occur and cannot be stalled.
module multi_trigger #(
    parameter int CH    = 4,
    parameter int DEB_W = 8
) (
    input  logic              Clock,
    input  logic              Rst_N,
    input  logic [CH-1:0]     Trig_In,
    input  logic              MNTrig_EN,
    input  logic [2*CH-1:0]   Edge_Sel,
    input  logic              Mode,
    input  logic [DEB_W-1:0]  Deb_Len,
    output logic              Trig_Dout,
    output logic              Trig_Pulse,
    output logic [CH-1:0]     Ch_Hit,
    output logic [15:0]       Trig_Cnt
);

    localparam logic [DEB_W-1:0] DEB_ONE = 1;

    logic [CH-1:0]    s_q, s_d;
    logic [CH-1:0]    f_q, f_d;
    logic [CH-1:0]    fd_q, fd_d;
    logic [DEB_W-1:0] deb_cnt_q [CH];
    logic [DEB_W-1:0] deb_cnt_d [CH];
    logic             dout_q, dout_d;
    logic             pulse_q, pulse_d;
    logic [CH-1:0]    ch_hit_q, ch_hit_d;
    logic [CH-1:0]    hit;
    logic             evt;

    // Debounce: a channel's filtered level follows the sample only after it has
    // disagreed for more than Deb_Len consecutive cycles; disabled means pass-through.
    always_comb begin
        s_d  = Trig_In;
        fd_d = f_q;
        f_d  = f_q;
        for (int i = 0; i < CH; i++) begin
            deb_cnt_d[i] = '0;
            if (!MNTrig_EN) begin
                f_d[i] = s_q[i];
            end else if (s_q[i] != f_q[i]) begin
                if (deb_cnt_q[i] >= Deb_Len) begin
                    f_d[i] = s_q[i];
                end else begin
                    deb_cnt_d[i] = deb_cnt_q[i] + DEB_ONE;
                end
            end
        end
    end

    always_comb begin
        hit = '0;
        for (int i = 0; i < CH; i++) begin
            hit[i] = (f_q[i] & ~fd_q[i] & Edge_Sel[2*i]) |
                     (~f_q[i] & fd_q[i] & Edge_Sel[2*i+1]);
        end
        evt = MNTrig_EN & (|hit);
    end

    always_comb begin
        pulse_d  = evt;
        dout_d   = Mode ? evt : (dout_q ^ evt);
        ch_hit_d = evt ? hit : ch_hit_q;
        if (!MNTrig_EN) begin
            dout_d   = 1'b0;
            ch_hit_d = '0;
        end
    end

    always_ff @(posedge Clock) begin
        if (!Rst_N) begin
            s_q      <= '0;
            f_q      <= '0;
            fd_q     <= '0;
            dout_q   <= 1'b0;
            pulse_q  <= 1'b0;
            ch_hit_q <= '0;
            for (int i = 0; i < CH; i++) deb_cnt_q[i] <= '0;
        end else begin
            s_q      <= s_d;
            f_q      <= f_d;
            fd_q     <= fd_d;
            dout_q   <= dout_d;
            pulse_q  <= pulse_d;
            ch_hit_q <= ch_hit_d;
            for (int i = 0; i < CH; i++) deb_cnt_q[i] <= deb_cnt_d[i];
        end
    end

`ifdef MULTI_TRIGGER_CNT_EN
    logic [15:0] trig_cnt_q, trig_cnt_d;

    always_comb begin
        trig_cnt_d = MNTrig_EN ? (trig_cnt_q + {15'd0, evt}) : 16'd0;
    end

    always_ff @(posedge Clock) begin
        if (!Rst_N) trig_cnt_q <= '0;
        else        trig_cnt_q <= trig_cnt_d;
    end

    assign Trig_Cnt = trig_cnt_q;
`else
    assign Trig_Cnt = '0;
`endif

    assign Trig_Dout  = dout_q;
    assign Trig_Pulse = pulse_q;
    assign Ch_Hit     = ch_hit_q;

endmodule

// File: doc/multi_trigger.md
MULTI_TRIGGER -- requirements
Module: multi_trigger

Interface
REQ-001 SHALL have parameter CH, default 4, meaning number of trigger input channels (1..16).
REQ-002 SHALL have parameter DEB_W, default 8, meaning width of the debounce length and per-channel debounce counters.
REQ-003 SHALL have port Clock, input, 1, meaning the single clock; all logic is on its rising edge.
REQ-004 SHALL have port Rst_N, input, 1, meaning reset; synchronous, active-low.
REQ-005 SHALL have port Trig_In, input, CH, meaning raw trigger levels, one bit per channel.
REQ-006 SHALL have port MNTrig_EN, input, 1, meaning block enable.
REQ-007 SHALL have port Edge_Sel, input, 2*CH, meaning per-channel edge select in bits [2i+1:2i]: 00 off, 01 rising, 10 falling, 11 both.
REQ-008 SHALL have port Mode, input, 1, meaning Trig_Dout mode: 0 toggle, 1 pulse.
REQ-009 SHALL have port Deb_Len, input, DEB_W, meaning debounce length in cycles.
REQ-010 SHALL have port Trig_Dout, output, 1, meaning trigger output (toggle or pulse per Mode).
REQ-011 SHALL have port Trig_Pulse, output, 1, meaning a one-cycle strobe per event, independent of Mode.
REQ-012 SHALL have port Ch_Hit, output, CH, meaning the mask of channels that caused the most recent event.
REQ-013 SHALL have port Trig_Cnt, output, 16, meaning the event count.

Function
REQ-014 SHALL register Trig_In into sample register S on every clock.
REQ-015 SHALL filter each channel i: when S[i]==F[i], counter cleared; otherwise counter increments, and when counter>=Deb_Len, F[i]<=S[i] and counter cleared.
REQ-016 SHALL register F into Fd each clock; rise[i]=F[i]&~Fd[i], fall[i]=~F[i]&Fd[i].
REQ-017 SHALL qualify hit[i]=(rise[i]&Edge_Sel[2i])|(fall[i]&Edge_Sel[2i+1]); event=OR of hit.
REQ-018 SHALL give latency: Trig_In change sampled at edge k, held stable, produces output at edge k+Deb_Len+2.
REQ-019 SHALL ignore a level held for fewer than Deb_Len+1 sampled cycles; Deb_Len=0 passes every sampled change.
REQ-020 SHALL apply a Deb_Len change mid-count immediately (>= comparison); no counter overflow.
REQ-021 SHALL set Trig_Pulse<=event each clock.
REQ-022 SHALL update Trig_Dout in toggle mode as Trig_Dout<=Trig_Dout^event, and in pulse mode as Trig_Dout<=event.
REQ-023 SHALL treat a Mode change as effective the next edge with no forced clear; pulse->toggle holds the current Trig_Dout value.
REQ-024 SHALL treat simultaneous hits on several channels in one cycle as one event (single toggle, count +1), with Ch_Hit holding all hit bits.
REQ-025 SHALL load Ch_Hit<=hit on an event cycle and hold it otherwise.
REQ-026 SHALL increment Trig_Cnt by 1 per event, wrapping 0xFFFF->0x0000.
REQ-027 SHALL, while MNTrig_EN=0: S/F/Fd track input (F<=S, Fd<=F, no debounce), counters 0, Trig_Dout/Trig_Pulse/Ch_Hit/Trig_Cnt 0, no events.
REQ-028 SHALL generate no spurious event on the MNTrig_EN 0->1 transition for a steady input level.

Reset
REQ-029 SHALL clear, on Rst_N=0 at a clock edge, S, F, Fd, all debounce counters, Trig_Dout, Trig_Pulse, Ch_Hit and Trig_Cnt to 0.
REQ-030 SHALL give reset priority over MNTrig_EN; reset mid-debounce discards the pending count.
REQ-031 SHALL detect a rising edge on a channel whose input is high at reset release with MNTrig_EN=1 (F starts at 0).

Configuration
REQ-032 SHALL, with macro MULTI_TRIGGER_CNT_EN defined, implement the Trig_Cnt counter per REQ-026.
REQ-033 SHALL, without MULTI_TRIGGER_CNT_EN, tie Trig_Cnt to 0 and include no counter logic; all other behaviour is unchanged.

Verification
REQ-034 SHALL cover: CH=4, Deb_Len=0, Edge_Sel=01 ch0, Mode=0; ch0 rises sampled edge k -> Trig_Dout 0->1 at k+2, Trig_Pulse high for cycle k+2, Ch_Hit=0001, Trig_Cnt=1.
REQ-035 SHALL cover: Deb_Len=3, ch1 Edge_Sel=11; 3-cycle glitch -> no event; 4-cycle high -> event at k+5, then fall -> second event, Trig_Cnt=2.
REQ-036 SHALL cover: ch0 rise and ch2 fall (Edge_Sel ch2=10) in the same cycle -> one toggle, Ch_Hit=0101, Trig_Cnt +1.
REQ-037 SHALL cover: Mode=1, ch0 rising edges spaced 5 cycles -> Trig_Dout one-cycle pulses equal to Trig_Pulse; Edge_Sel=00 -> no pulses.
REQ-038 SHALL cover: Trig_In=1111 held, MNTrig_EN toggled 0->1 -> no event; Trig_Cnt preset to 0xFFFF then one event -> 0x0000.
REQ-039 SHALL cover: Rst_N=0 during an active debounce count -> all outputs 0 on the next edge; build without MULTI_TRIGGER_CNT_EN -> Trig_Cnt stays 0.
